// File: rtl/vga_bounce_box.sv
`default_nettype none
// ============================================================================
//  Module   : vga_bounce_box
//  Purpose  : Pixel-colour source for the VGA output path. Draws a solid box
//             over a blue background. The box moves once per frame, bounces
//             off the edges of the active area, and changes colour on every
//             bounce.
//  Revision : 1.0  initial release
// ============================================================================
module vga_bounce_box #(
    parameter int H_ORG   = 281,
    parameter int V_ORG   = 35,
    parameter int H_SPAN  = 1278,
    parameter int V_SPAN  = 479,
    parameter int BOX_W   = 80,
    parameter int BOX_H   = 40,
    parameter int SPEED_X = 4,
    parameter int SPEED_Y = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        active,
    input  logic        frame_tick,
    input  logic        freeze,
    output logic        rgb_r,
    output logic        rgb_g,
    output logic        rgb_b,
    output logic [10:0] x_pos,
    output logic [9:0]  y_pos,
    output logic [7:0]  hit_count
);

    // All limit compares are done at 12 bits so that no sum can wrap.
    localparam logic [11:0] c_X_LIM  = 12'(H_SPAN - BOX_W);
    localparam logic [11:0] c_Y_LIM  = 12'(V_SPAN - BOX_H);
    localparam logic [11:0] c_SX     = 12'(SPEED_X);
    localparam logic [11:0] c_SY     = 12'(SPEED_Y);
    localparam logic [11:0] c_H_ORG  = 12'(H_ORG);
    localparam logic [11:0] c_V_ORG  = 12'(V_ORG);
    localparam logic [11:0] c_BOX_W  = 12'(BOX_W);
    localparam logic [11:0] c_BOX_H  = 12'(BOX_H);

    // Native-width copies used for the actual position arithmetic.
    localparam logic [10:0] c_X_LIM11 = 11'(H_SPAN - BOX_W);
    localparam logic [9:0]  c_Y_LIM10 = 10'(V_SPAN - BOX_H);
    localparam logic [10:0] c_SX11    = 11'(SPEED_X);
    localparam logic [9:0]  c_SY10    = 10'(SPEED_Y);

    localparam logic [2:0]  c_COLOUR_INIT = 3'b111;
    localparam logic [2:0]  c_BLUE        = 3'b001;
    localparam logic [2:0]  c_BLACK       = 3'b000;

    logic [10:0] r_x_pos;
    logic [9:0]  r_y_pos;
    logic        r_dir_x;
    logic        r_dir_y;
    logic [2:0]  r_colour;
    logic [7:0]  r_hit_count;
    logic [2:0]  r_rgb;

    logic [10:0] w_x_next;
    logic [9:0]  w_y_next;
    logic        w_dir_x_next;
    logic        w_dir_y_next;
    logic        w_x_hit;
    logic        w_y_hit;
    logic        w_move;
    logic        w_bounce;
    logic [2:0]  w_colour_next;

    logic [11:0] w_x_lo;
    logic [11:0] w_x_hi;
    logic [11:0] w_y_lo;
    logic [11:0] w_y_hi;
    logic [11:0] w_h;
    logic [11:0] w_v;
    logic        w_in_box;

    assign w_move   = frame_tick & ~freeze;
    assign w_bounce = w_x_hit | w_y_hit;

    // Horizontal next position, direction and wall hit.
    always_comb begin
        w_x_next     = r_x_pos;
        w_dir_x_next = r_dir_x;
        w_x_hit      = 1'b0;
        if (r_dir_x) begin
            if (({1'b0, r_x_pos} + c_SX) >= c_X_LIM) begin
                w_x_next     = c_X_LIM11;
                w_dir_x_next = 1'b0;
                w_x_hit      = 1'b1;
            end else begin
                w_x_next = r_x_pos + c_SX11;
            end
        end else begin
            if ({1'b0, r_x_pos} <= c_SX) begin
                w_x_next     = 11'd0;
                w_dir_x_next = 1'b1;
                w_x_hit      = 1'b1;
            end else begin
                w_x_next = r_x_pos - c_SX11;
            end
        end
    end

    // Vertical next position, direction and wall hit.
    always_comb begin
        w_y_next     = r_y_pos;
        w_dir_y_next = r_dir_y;
        w_y_hit      = 1'b0;
        if (r_dir_y) begin
            if (({2'b00, r_y_pos} + c_SY) >= c_Y_LIM) begin
                w_y_next     = c_Y_LIM10;
                w_dir_y_next = 1'b0;
                w_y_hit      = 1'b1;
            end else begin
                w_y_next = r_y_pos + c_SY10;
            end
        end else begin
            if ({2'b00, r_y_pos} <= c_SY) begin
                w_y_next     = 10'd0;
                w_dir_y_next = 1'b1;
                w_y_hit      = 1'b1;
            end else begin
                w_y_next = r_y_pos - c_SY10;
            end
        end
    end

    // Colour sequence steps down from 111 to 001 and wraps, never showing 000.
    always_comb begin
        w_colour_next = r_colour - 3'd1;
        if (r_colour == c_BLUE) begin
            w_colour_next = c_COLOUR_INIT;
        end
    end

    // Motion state: updated only on an unfrozen frame tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_x_pos     <= 11'd0;
            r_y_pos     <= 10'd0;
            r_dir_x     <= 1'b1;
            r_dir_y     <= 1'b1;
            r_colour    <= c_COLOUR_INIT;
            r_hit_count <= 8'd0;
        end else if (w_move) begin
            r_x_pos <= w_x_next;
            r_y_pos <= w_y_next;
            r_dir_x <= w_dir_x_next;
            r_dir_y <= w_dir_y_next;
            // A corner hit on both axes is a single bounce event.
            if (w_bounce) begin
                r_colour    <= w_colour_next;
                r_hit_count <= r_hit_count + 8'd1;
            end
        end
    end

    // Box window in counter coordinates, compared against registered position.
    always_comb begin
        w_h      = {1'b0, h_cnt};
        w_v      = {2'b00, v_cnt};
        w_x_lo   = c_H_ORG + {1'b0, r_x_pos};
        w_x_hi   = w_x_lo + c_BOX_W;
        w_y_lo   = c_V_ORG + {2'b00, r_y_pos};
        w_y_hi   = w_y_lo + c_BOX_H;
        w_in_box = (w_h >= w_x_lo) && (w_h < w_x_hi) &&
                   (w_v >= w_y_lo) && (w_v < w_y_hi);
    end

    // Registered pixel colour: black when blanked, box colour or blue otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rgb <= c_BLACK;
        end else if (!active) begin
            r_rgb <= c_BLACK;
        end else if (w_in_box) begin
            r_rgb <= r_colour;
        end else begin
            r_rgb <= c_BLUE;
        end
    end

    assign rgb_r     = r_rgb[2];
    assign rgb_g     = r_rgb[1];
    assign rgb_b     = r_rgb[0];
    assign x_pos     = r_x_pos;
    assign y_pos     = r_y_pos;
    assign hit_count = r_hit_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_bounce_box.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_bounce_box
//  Purpose  : Directed, self-checking bench for vga_bounce_box: pixel table,
//             motion/bounce sequences, freeze, corner bounce and mid-run reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_bounce_box;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst2 = 1'b0;
    logic [10:0] h_cnt = '0;
    logic [9:0]  v_cnt = '0;
    logic        active = 1'b0;
    logic        frame_tick = 1'b0;
    logic        frame_tick2 = 1'b0;
    logic        freeze = 1'b0;

    logic        rgb_r, rgb_g, rgb_b;
    logic [10:0] x_pos;
    logic [9:0]  y_pos;
    logic [7:0]  hit_count;

    logic        c_rgb_r, c_rgb_g, c_rgb_b;
    logic [10:0] c_x_pos;
    logic [9:0]  c_y_pos;
    logic [7:0]  c_hit_count;

    int n_pass  = 0;
    int n_total = 0;

    always #10 clk = ~clk;

    vga_bounce_box dut (
        .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .active(active),
        .frame_tick(frame_tick), .freeze(freeze),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
        .x_pos(x_pos), .y_pos(y_pos), .hit_count(hit_count)
    );

    // Small arena so both walls are reached on the same tick (limits 10,10).
    vga_bounce_box #(
        .H_SPAN(90), .V_SPAN(50), .BOX_W(80), .BOX_H(40),
        .SPEED_X(1), .SPEED_Y(1)
    ) dut_corner (
        .clk(clk), .rst(rst2), .h_cnt(h_cnt), .v_cnt(v_cnt), .active(active),
        .frame_tick(frame_tick2), .freeze(1'b0),
        .rgb_r(c_rgb_r), .rgb_g(c_rgb_g), .rgb_b(c_rgb_b),
        .x_pos(c_x_pos), .y_pos(c_y_pos), .hit_count(c_hit_count)
    );

    typedef struct {
        int       h;
        int       v;
        logic     act;
        logic [2:0] exp_rgb;
    } vec_t;

    task automatic check(input string name, input int act_v, input int exp_v);
        n_total++;
        if (act_v !== exp_v)
            $display("FAIL %s: got %0d, expected %0d", name, act_v, exp_v);
        else
            n_pass++;
    endtask

    // Present one pixel and capture the registered colour one clock later.
    task automatic pixel(input int h, input int v, input logic a, output logic [2:0] rgb);
        @(negedge clk);
        h_cnt  = 11'(h);
        v_cnt  = 10'(v);
        active = a;
        @(posedge clk);
        #1;
        rgb = {rgb_r, rgb_g, rgb_b};
    endtask

    task automatic pixel_c(input int h, input int v, output logic [2:0] rgb);
        @(negedge clk);
        h_cnt  = 11'(h);
        v_cnt  = 10'(v);
        active = 1'b1;
        @(posedge clk);
        #1;
        rgb = {c_rgb_r, c_rgb_g, c_rgb_b};
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    task automatic tick_c(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_tick2 = 1'b1;
            @(negedge clk);
            frame_tick2 = 1'b0;
        end
    endtask

    initial begin
        vec_t       vecs[8];
        logic [2:0] rgb;

        // Box at (0,0): columns 281..360, lines 35..74, colour 111.
        vecs[0] = '{h: 281, v: 35, act: 1'b1, exp_rgb: 3'b111};
        vecs[1] = '{h: 361, v: 35, act: 1'b1, exp_rgb: 3'b001};
        vecs[2] = '{h: 360, v: 35, act: 1'b1, exp_rgb: 3'b111};
        vecs[3] = '{h: 280, v: 35, act: 1'b1, exp_rgb: 3'b001};
        vecs[4] = '{h: 281, v: 74, act: 1'b1, exp_rgb: 3'b111};
        vecs[5] = '{h: 281, v: 75, act: 1'b1, exp_rgb: 3'b001};
        vecs[6] = '{h: 281, v: 35, act: 1'b0, exp_rgb: 3'b000};
        vecs[7] = '{h: 300, v: 50, act: 1'b1, exp_rgb: 3'b111};

        // Reset held two cycles, with a tick present to show reset priority.
        rst = 1'b0; rst2 = 1'b0; frame_tick = 1'b1; active = 1'b1;
        h_cnt = 11'd281; v_cnt = 10'd35;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rgb", {rgb_r, rgb_g, rgb_b}, 0);
        check("reset_x", x_pos, 0);
        check("reset_y", y_pos, 0);
        check("reset_hits", hit_count, 0);
        @(negedge clk);
        frame_tick = 1'b0; active = 1'b0;
        rst = 1'b1; rst2 = 1'b1;

        for (int i = 0; i < 8; i++) begin
            pixel(vecs[i].h, vecs[i].v, vecs[i].act, rgb);
            check($sformatf("pix_vec%0d", i), rgb, vecs[i].exp_rgb);
        end

        // Single step.
        tick(1);
        check("step_x", x_pos, 4);
        check("step_y", y_pos, 2);
        check("step_hits", hit_count, 0);
        pixel(285, 37, 1'b1, rgb);
        check("step_pix_in", rgb, 3'b111);
        pixel(284, 37, 1'b1, rgb);
        check("step_pix_left", rgb, 3'b001);

        // Approach and hit the bottom wall.
        tick(218);
        check("t219_y", y_pos, 438);
        check("t219_hits", hit_count, 0);
        tick(1);
        check("t220_y", y_pos, 439);
        check("t220_x", x_pos, 880);
        check("t220_hits", hit_count, 1);
        pixel(281 + 880, 35 + 439, 1'b1, rgb);
        check("t220_colour", rgb, 3'b110);

        // Right wall on tick 300; y has been rising for 80 ticks.
        tick(80);
        check("t300_x", x_pos, 1198);
        check("t300_y", y_pos, 279);
        check("t300_hits", hit_count, 2);
        pixel(281 + 1198, 35 + 279, 1'b1, rgb);
        check("t300_colour", rgb, 3'b101);
        tick(1);
        check("t301_x", x_pos, 1194);
        check("t301_y", y_pos, 277);

        // Freeze holds everything.
        @(negedge clk); freeze = 1'b1;
        tick(10);
        check("frz_x", x_pos, 1194);
        check("frz_y", y_pos, 277);
        check("frz_hits", hit_count, 2);
        pixel(281 + 1194, 35 + 277, 1'b1, rgb);
        check("frz_colour", rgb, 3'b101);
        @(negedge clk); freeze = 1'b0;
        tick(1);
        check("unfrz_x", x_pos, 1190);
        check("unfrz_y", y_pos, 275);

        // Reset asserted during active video, inside the box.
        @(negedge clk);
        h_cnt = 11'd1471; v_cnt = 10'd310; active = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_rgb", {rgb_r, rgb_g, rgb_b}, 0);
        check("mrst_x", x_pos, 0);
        check("mrst_y", y_pos, 0);
        check("mrst_hits", hit_count, 0);
        @(negedge clk); rst = 1'b1; active = 1'b0;
        pixel(281, 35, 1'b1, rgb);
        check("mrst_colour", rgb, 3'b111);
        tick(1);
        check("mrst_step_x", x_pos, 4);
        check("mrst_step_y", y_pos, 2);

        // Corner bounce: both limits are 10 with unit speed.
        tick_c(9);
        check("crn_pre_x", c_x_pos, 9);
        check("crn_pre_hits", c_hit_count, 0);
        tick_c(1);
        check("crn_x", c_x_pos, 10);
        check("crn_y", c_y_pos, 10);
        check("crn_hits", c_hit_count, 1);
        pixel_c(281 + 10, 35 + 10, rgb);
        check("crn_colour", rgb, 3'b110);
        tick_c(1);
        check("crn_back_x", c_x_pos, 9);
        check("crn_back_y", c_y_pos, 9);
        check("crn_back_hits", c_hit_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #5ms;
        $display("FAIL timeout: got no finish, expected finish before 5ms");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
